imem_dmem_arbiter: RTL
======================

# imem_dmem_arbiter

Shares a single 64-bit memory port between the instruction fetch stage and the load/store unit. One transaction is outstanding at a time. Data accesses have priority, and a bounded-streak rule prevents fetch starvation. The block drives the fetch-stage stall and discards fetch responses that are made stale by a pipeline flush. It sits between `instruction_fetch`/`mem_stage` and the memory model/controller.

## Interface
- `ADDR_W`, 64, address width for both requesters and the memory port
- `MAX_DATA_STREAK`, 4, consecutive data grants allowed while fetch waits (≥1)
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_if_req`  in  1  fetch request; held until `o_if_valid`
- `i_if_addr`  in  ADDR_W  fetch byte address, 4-byte aligned
- `i_flush`  in  1  pipeline flush; invalidates any pending fetch
- `o_if_valid`  out  1  one-cycle pulse: `o_if_instr` is valid
- `o_if_instr`  out  32  fetched instruction word
- `o_if_stall`  out  1  `i_if_req && !o_if_valid` (combinational)
- `i_dm_req`  in  1  data request; held until `o_dm_done`
- `i_dm_we`  in  1  1 = store, 0 = load
- `i_dm_addr`  in  ADDR_W  data byte address, 8-byte aligned
- `i_dm_wdata`  in  64  store data
- `i_dm_wstrb`  in  8  byte enables for the store
- `o_dm_done`  out  1  one-cycle pulse: access complete
- `o_dm_rdata`  out  64  load data; valid when `o_dm_done` is high and the access was a load
- `o_mem_req`, `o_mem_we`, `o_mem_addr[ADDR_W]`, `o_mem_wdata[64]`, `o_mem_wstrb[8]`  out  memory command; held stable until `i_mem_gnt`
- `i_mem_gnt`  in  1  command accepted in this cycle
- `i_mem_rvalid`  in  1  response or write ack; one cycle
- `i_mem_rdata`  in  64  read data

## Operation
- FSM states:
  - IDLE: pick an owner if any request is present, latch the command, go to REQ.
  - REQ: `o_mem_req`=1; on `i_mem_gnt` go to WAIT.
  - WAIT: on `i_mem_rvalid` go to RESP.
  - RESP: pulse the owner's done/valid output (unless discarded), then go to IDLE.
- Arbitration in IDLE:
  - Data wins, unless `streak == MAX_DATA_STREAK` and `i_if_req`; in that case fetch wins.
  - `streak` increments on each data win while `i_if_req`=1, saturating at `MAX_DATA_STREAK`.
  - `streak` clears on a fetch win, and on a data win with `i_if_req`=0.
- Command latching:
  - Owner, address, we, wdata and wstrb are registered in IDLE.
  - Requester inputs are ignored after latching.
  - A fetch is always a read with wstrb = 8'h00.
- Fetch word select: `o_if_instr` = latched addr[2] ? rdata[63:32] : rdata[31:0]. The address is passed through unaligned to 8 bytes.
- Flush:
  - `i_flush` while fetch owns REQ/WAIT/RESP sets `discard`. The transaction still completes on the memory side; it is never withdrawn.
  - In RESP with `discard`=1, `o_if_valid` stays 0.
  - `discard` clears on return to IDLE.
  - `i_flush` in IDLE, or while data owns the port, has no effect on the arbiter.
- Writes complete on `i_mem_rvalid` as an ack; `o_dm_rdata` is don't-care for stores.
- Simultaneous `i_mem_gnt` and `i_mem_rvalid` in REQ is illegal under the memory protocol; assert in simulation.
- Reset mid-transaction:
  - Abandons the transaction: state → IDLE, all pulses low.
  - The memory side is reset by the same `i_rst_n`.

## Timing
- Reset values:
  - state IDLE; `streak` 0; `discard` 0.
  - `o_mem_req`, `o_mem_we`, `o_if_valid`, `o_dm_done` = 0.
  - `o_if_instr`, `o_dm_rdata`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wstrb` = 0.
- All outputs are registered except `o_if_stall`.
- Latency, request sampled at edge N:
  - `o_mem_req` high in cycle N+1.
  - With `i_mem_gnt` in N+1 and `i_mem_rvalid` in N+2, the done/valid pulse occurs in N+3.
  - Minimum 3 cycles request-to-response; 4 cycles issue-to-issue back-to-back.
- `o_if_instr`/`o_dm_rdata` update only in RESP and hold their value afterwards.
- `o_mem_*` command fields hold their value while `o_mem_req`=1 and `i_mem_gnt`=0.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, REQ, WAIT, RESP}
  - `arb_owner_t` enum {OWN_IF, OWN_DM}
  - `MEM_DATA_W`=64, `INSTR_W`=32
- Single module; no sub-module is warranted. The priority/streak logic is about 15 lines inline.
- Streak counter width: `$clog2(MAX_DATA_STREAK+1)`.

## Test plan
- Fetch only:
  - Stimulus: `i_if_addr`=0x4; memory returns 0xAAAA_BBBB_1111_2222 with gnt on the first cycle.
  - Response: `o_if_instr`=0xAAAABBBB 3 cycles after the request; `o_if_stall` high for exactly 3 cycles.
- Both requesting in IDLE, data load at 0x10:
  - Response: data granted first; `o_dm_done` then `o_if_valid` 4 cycles apart.
- Data held continuously with fetch pending, `MAX_DATA_STREAK`=4:
  - Response: grant order D,D,D,D,F,D,…; streak returns to 0 after F.
- `i_flush` while a fetch is in WAIT:
  - Response: memory still sees one req/rvalid; `o_if_valid` never pulses; the next fetch is served normally.
- Store with wstrb=0x0F, gnt delayed 3 cycles:
  - Response: `o_mem_addr`/`o_mem_wdata`/`o_mem_wstrb` stable across all 4 req cycles; `o_dm_done` 1 cycle after rvalid.
- `i_rst_n` low during WAIT:
  - Response: all outputs at their reset values immediately; after release, a new fetch completes in 3 cycles.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// mem_arb_pkg: shared state/owner types and data widths for the imem/dmem arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
    localparam int MEM_DATA_W = 64;
    localparam int INSTR_W = 32;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch, load/store and memory-port signals of the arbiter.
interface imem_dmem_arbiter_if #(parameter int ADDR_W = 64);
    import mem_arb_pkg::*;
    logic                  i_if_req;
    logic [ADDR_W-1:0]     i_if_addr;
    logic                  i_flush;
    logic                  o_if_valid;
    logic [INSTR_W-1:0]    o_if_instr;
    logic                  o_if_stall;
    logic                  i_dm_req;
    logic                  i_dm_we;
    logic [ADDR_W-1:0]     i_dm_addr;
    logic [MEM_DATA_W-1:0] i_dm_wdata;
    logic [7:0]            i_dm_wstrb;
    logic                  o_dm_done;
    logic [MEM_DATA_W-1:0] o_dm_rdata;
    logic                  o_mem_req;
    logic                  o_mem_we;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [MEM_DATA_W-1:0] o_mem_wdata;
    logic [7:0]            o_mem_wstrb;
    logic                  i_mem_gnt;
    logic                  i_mem_rvalid;
    logic [MEM_DATA_W-1:0] i_mem_rdata;
    modport slave (
        input  i_if_req, i_if_addr, i_flush, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wstrb,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_if_valid, o_if_instr, o_if_stall, o_dm_done, o_dm_rdata,
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
    modport master (
        output i_if_req, i_if_addr, i_flush, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_wstrb,
               i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_if_valid, o_if_instr, o_if_stall, o_dm_done, o_dm_rdata,
               o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one memory port between fetch and load/store, data first with a bounded streak.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 64,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    imem_dmem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

    arb_state_t state, state_n;
    arb_owner_t owner;
    logic [SW-1:0] streak;
    logic discard;
    logic any_req, dm_win;

    assign bus.o_if_stall = bus.i_if_req && !bus.o_if_valid;

    always_comb begin
        state_n = state;
        any_req = bus.i_if_req || bus.i_dm_req;
        dm_win = bus.i_dm_req && !(streak == SMAX && bus.i_if_req);
        case (state)
            IDLE:    state_n = any_req ? REQ : IDLE;
            REQ:     state_n = bus.i_mem_gnt ? WAIT : REQ;
            WAIT:    state_n = bus.i_mem_rvalid ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            owner           <= OWN_IF;
            streak          <= '0;
            discard         <= 1'b0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_mem_wstrb <= '0;
            bus.o_if_valid  <= 1'b0;
            bus.o_if_instr  <= '0;
            bus.o_dm_done   <= 1'b0;
            bus.o_dm_rdata  <= '0;
        end else begin
            state          <= state_n;
            bus.o_if_valid <= 1'b0;
            bus.o_dm_done  <= 1'b0;
            if (state == IDLE && any_req) begin
                owner           <= dm_win ? OWN_DM : OWN_IF;
                // a data win with fetch waiting implies streak < max, so no saturation needed
                streak          <= (dm_win && bus.i_if_req) ? streak + 1'b1 : '0;
                bus.o_mem_req   <= 1'b1;
                bus.o_mem_we    <= dm_win && bus.i_dm_we;
                bus.o_mem_addr  <= dm_win ? bus.i_dm_addr : bus.i_if_addr;
                bus.o_mem_wdata <= dm_win ? bus.i_dm_wdata : '0;
                bus.o_mem_wstrb <= dm_win ? bus.i_dm_wstrb : '0;
            end
            if (state == REQ && bus.i_mem_gnt)
                bus.o_mem_req <= 1'b0;
            if (state != IDLE && owner == OWN_IF && bus.i_flush)
                discard <= 1'b1;
            if (state == WAIT && bus.i_mem_rvalid) begin
                if (owner == OWN_DM) begin
                    bus.o_dm_done  <= 1'b1;
                    bus.o_dm_rdata <= bus.i_mem_rdata;
                end else if (!(discard || bus.i_flush)) begin
                    bus.o_if_valid <= 1'b1;
                    bus.o_if_instr <= bus.o_mem_addr[2] ? bus.i_mem_rdata[63:32] : bus.i_mem_rdata[31:0];
                end
            end
            if (state == RESP)
                discard <= 1'b0;
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(state == REQ && bus.i_mem_gnt && bus.i_mem_rvalid));
endmodule
